pipe_rr_scheduler: RTL

//   Shares a DEPTH-stage register delay pipeline (in->reg->out chain) between NUM_REQ requesters.
//   A round-robin arbiter grants one requester per accepted beat. Each beat is tagged with its

---
 rtl/pipe_rr_scheduler_if.sv | 30 +++
 rtl/pipe_rr_scheduler.sv | 97 +++++++++
 2 files changed

// File: rtl/pipe_rr_scheduler_if.sv
// Bundle of the requester-side and output-side handshake signals of pipe_rr_scheduler.
// The master modport is the environment side; the slave modport is the scheduler.
interface pipe_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 2,
  parameter int DEPTH   = 2
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      flush;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_ready;
  logic [OCC_W-1:0]          occupancy;

  modport master (
    output req_valid, req_data, flush, out_ready,
    input  req_ready, out_valid, out_data, out_id, occupancy
  );

  modport slave (
    input  req_valid, req_data, flush, out_ready,
    output req_ready, out_valid, out_data, out_id, occupancy
  );
endinterface

// File: rtl/pipe_rr_scheduler.sv
// Round-robin scheduler feeding a shared DEPTH-stage delay line; every beat carries its requester ID
// and the whole line stalls as one unit when the output is backpressured.
module pipe_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 2,
  parameter int DEPTH   = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  pipe_rr_scheduler_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  stage_valid;
  logic [DATA_W-1:0] stage_data [DEPTH];
  logic [ID_W-1:0]   stage_id   [DEPTH];
  logic [ID_W-1:0]   ptr;
  logic [OCC_W-1:0]  occ;

  logic              adv;
  logic              accept;
  logic              xfer;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [DATA_W-1:0] grant_data;
  int                cand;

  assign bus.out_valid = stage_valid[DEPTH-1];
  assign bus.out_data  = stage_data[DEPTH-1];
  assign bus.out_id    = stage_id[DEPTH-1];
  assign bus.occupancy = occ;

  // A full line can still take a beat as long as the last stage drains this cycle.
  assign adv    = !bus.out_valid || bus.out_ready;
  assign xfer   = bus.out_valid && bus.out_ready;
  assign accept = adv && !bus.flush && !sys_rst && grant_found;

  // Scan from the pointer upward with wraparound; first active requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!grant_found && bus.req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  // Flush only kills valids; stale payload in a dead stage is never observed.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stage_valid <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        stage_data[s] <= '0;
        stage_id[s]   <= '0;
      end
      ptr <= '0;
      occ <= '0;
    end else if (bus.flush) begin
      stage_valid <= '0;
      occ         <= '0;
    end else if (adv) begin
      stage_valid[0] <= accept;
      stage_data[0]  <= accept ? grant_data : '0;
      stage_id[0]    <= accept ? grant_idx : '0;
      for (int s = 1; s < DEPTH; s++) begin
        stage_valid[s] <= stage_valid[s-1];
        stage_data[s]  <= stage_data[s-1];
        stage_id[s]    <= stage_id[s-1];
      end
      if (accept) begin
        ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      occ <= occ + OCC_W'(accept) - OCC_W'(xfer);
    end
  end
endmodule
